// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single GPR write port between the in-order pipeline writeback
//   stage and an out-of-band long-latency unit (mul/div).
//
//   The pipeline always has priority and is never back-pressured.
//   External results are queued in a small FIFO.
//   Queued results drain into cycles where the pipeline does not write.
//   If the FIFO head waits STARVE_LIMIT cycles, the block raises stall_o.
//   The stall forces a free slot.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   pipe_wr_valid_i     pipeline write request (rd == 0 counts as no request)
//   pipe_rd_i           pipeline destination register
//   pipe_wdata_i        pipeline write data
//   ext_valid_i         external result valid
//   ext_ready_o         FIFO has room (push on ext_valid_i && ext_ready_o)
//   ext_rd_i            external destination register
//   ext_wdata_i         external write data
//   stall_o             ask the pipeline to stop presenting writes
//   gpr_we_o            registered GPR write enable
//   gpr_waddr_o         registered GPR write address
//   gpr_wdata_o         registered GPR write data
//   ext_commit_o        pulses with gpr_we_o when the write came from the FIFO
//
// Optional build macro WB_ARB_STATS_EN adds saturating 32-bit counters:
//   pipe_grants_o       pipeline writes performed
//   ext_grants_o        external writes performed
//   stall_cycles_o      cycles with stall_o asserted
module wb_port_arbiter #(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     pipe_wr_valid_i,
  input  logic [RF_ADDR_WIDTH-1:0] pipe_rd_i,
  input  logic [DATA_WIDTH-1:0]    pipe_wdata_i,
  input  logic                     ext_valid_i,
  output logic                     ext_ready_o,
  input  logic [RF_ADDR_WIDTH-1:0] ext_rd_i,
  input  logic [DATA_WIDTH-1:0]    ext_wdata_i,
  output logic                     stall_o,
  output logic                     gpr_we_o,
  output logic [RF_ADDR_WIDTH-1:0] gpr_waddr_o,
  output logic [DATA_WIDTH-1:0]    gpr_wdata_o,
  output logic                     ext_commit_o
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]              pipe_grants_o,
  output logic [31:0]              ext_grants_o,
  output logic [31:0]              stall_cycles_o
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]       LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic {IDLE, STEAL} state_t;

  logic [RF_ADDR_WIDTH-1:0] rd_mem   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;
  logic [7:0]               starve_cnt;
  state_t                   state;
  state_t                   state_next;

  logic fifo_empty;
  logic pipe_req;
  logic push;
  logic pop;

  assign fifo_empty  = (count == '0);
  assign ext_ready_o = (count != FULL);
  assign pipe_req    = pipe_wr_valid_i && (pipe_rd_i != '0);
  // Writes to x0 complete the handshake but are never enqueued.
  assign push        = ext_valid_i && ext_ready_o && (ext_rd_i != '0);
  // The pop decision uses only the registered count.
  // An entry pushed this cycle therefore cannot drain until the next cycle.
  assign pop         = !pipe_req && !fifo_empty;
  assign stall_o     = (state == STEAL);

  // NOTE: storage is deliberately not reset; count alone says which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      rd_mem[wr_ptr]   <= ext_rd_i;
      data_mem[wr_ptr] <= ext_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Power-of-two depth lets the pointers wrap naturally.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Counts cycles in which the FIFO head waited, saturating at the limit.
  always_ff @(posedge clk_i) begin
    if (rst_i || pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:  if (!pop && !fifo_empty && (starve_cnt == LIMIT)) state_next = STEAL;
      STEAL: if (pop || fifo_empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A grant decided this cycle appears on the write port next cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      gpr_we_o     <= 1'b0;
      gpr_waddr_o  <= '0;
      gpr_wdata_o  <= '0;
      ext_commit_o <= 1'b0;
    end else begin
      gpr_we_o     <= pipe_req || pop;
      ext_commit_o <= pop;
      if (pipe_req) begin
        gpr_waddr_o <= pipe_rd_i;
        gpr_wdata_o <= pipe_wdata_i;
      end else if (pop) begin
        gpr_waddr_o <= rd_mem[rd_ptr];
        gpr_wdata_o <= data_mem[rd_ptr];
      end
    end
  end

`ifdef WB_ARB_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_grants_o  <= '0;
      ext_grants_o   <= '0;
      stall_cycles_o <= '0;
    end else begin
      if (pipe_req && (pipe_grants_o != '1))  pipe_grants_o  <= pipe_grants_o + 1'b1;
      if (pop && (ext_grants_o != '1))        ext_grants_o   <= ext_grants_o + 1'b1;
      if (stall_o && (stall_cycles_o != '1))  stall_cycles_o <= stall_cycles_o + 1'b1;
    end
  end
`endif

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Sequences the single GPR write port between two requesters: the in-order pipeline writeback stage and an out-of-band long-latency unit (e.g. multiply/divide).
- The pipeline write has fixed priority and is never back-pressured. Long-latency results are buffered in a small FIFO and drained into free slots.
- A starvation counter requests a pipeline stall to force a free slot when needed.
- Sits between the writeback stage/long-latency unit and the GPR file write port.

Parameters:
- RF_ADDR_WIDTH, 5, GPR index width (from core_pkg)
- DATA_WIDTH, 32, GPR data width (from core_pkg)
- FIFO_DEPTH, 2, external result buffer entries; power of two, >= 2
- STARVE_LIMIT, 4, cycles a non-empty FIFO may go unserved before a stall is requested; range 1..255

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- pipe_wr_valid_i  in  1  pipeline writeback requests a GPR write this cycle
- pipe_rd_i  in  RF_ADDR_WIDTH  pipeline destination register
- pipe_wdata_i  in  DATA_WIDTH  pipeline write data
- ext_valid_i  in  1  long-latency unit presents a result
- ext_ready_o  out  1  FIFO can accept a result
- ext_rd_i  in  RF_ADDR_WIDTH  external destination register
- ext_wdata_i  in  DATA_WIDTH  external write data
- stall_o  out  1  request that the pipeline present no write from the next cycle
- gpr_we_o  out  1  GPR write enable
- gpr_waddr_o  out  RF_ADDR_WIDTH  GPR write address
- gpr_wdata_o  out  DATA_WIDTH  GPR write data
- ext_commit_o  out  1  one-cycle pulse: an external entry was written this cycle

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values: gpr_we_o=0, gpr_waddr_o=0, gpr_wdata_o=0, stall_o=0, ext_commit_o=0. ext_ready_o=1 the cycle after reset. FIFO empty, counter 0, state IDLE.
- Reset mid-operation discards all FIFO contents.
- Write-port outputs are registered: a grant decided in cycle t appears on gpr_* in cycle t+1, held for exactly one cycle.
- Writes to x0: a pipeline request with rd=0 is treated as no request, and its slot counts as free. An external push with rd=0 is accepted by the handshake but not enqueued.
- Push handshake: an entry is pushed when ext_valid_i && ext_ready_o. ext_ready_o = (count != FIFO_DEPTH), derived from the registered count.
- Simultaneous push and pop leaves count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Grant priority, each cycle:
  - Pipeline request valid (rd != 0): grant the pipeline.
  - Otherwise, FIFO non-empty: pop the head and grant it. ext_commit_o pulses in the cycle the write appears.
  - A pushed entry is poppable at the earliest the cycle after the push; there is no bypass.
- Starvation counter (8-bit):
  - Increments each cycle the FIFO is non-empty and not popped.
  - Clears on a pop and when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- FSM:
  - IDLE -> STEAL when the counter reaches STARVE_LIMIT.
  - STEAL: stall_o=1, registered (asserted the cycle after the transition). Pipeline grant keeps priority, since the pipeline honours stall_o one cycle late and an in-flight write may still arrive.
  - STEAL -> IDLE on the cycle a pop occurs. stall_o drops the following cycle.
  - STEAL -> IDLE if the FIFO becomes empty by any means, including reset.
- Ordering hazards between pipeline and external writes to the same rd are outside this block's scope; the scoreboard owns them.

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- When defined, adds outputs:
  - pipe_grants_o [31:0]: pipeline writes performed.
  - ext_grants_o [31:0]: external writes performed.
  - stall_cycles_o [31:0]: cycles with stall_o=1.
  - All three are saturating and cleared by rst_i.
- When undefined, these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset then idle 5 cycles: gpr_we_o=0, stall_o=0, ext_ready_o=1 throughout.
- Pipeline write rd=3, data 0xDEADBEEF at cycle t, with an external push rd=7, data 0x11 also at t: cycle t+1 shows rd=3/0xDEADBEEF; cycle t+2 shows rd=7/0x11 with ext_commit_o=1.
- FIFO_DEPTH=2: push 3 results back-to-back with continuous pipeline writes. The third is held, ext_ready_o=0 after two pushes, and the third is accepted only after a pop.
- STARVE_LIMIT=4, one queued entry, pipeline writes every cycle: stall_o rises after 4 unserved cycles. The entry is written in the first pipeline-free cycle, and stall_o falls the cycle after that.
- Pipeline rd=0 with a queued entry: the queued entry is granted in that slot. An external push with rd=0 produces no GPR write and no ext_commit_o.
- rst_i asserted with 2 entries queued and stall_o=1: next cycle the FIFO is empty, stall_o=0, and no write to the queued registers ever occurs.
